// File: rtl/xmult_acc.sv
`default_nettype none
// ============================================================================
// Module   : xmult_acc
// Purpose  : Accumulates N_TERMS unsigned xMult products into one dot-product
//            sum with valid/ready handshakes on both sides and a sticky carry.
// Revision : 1.0  initial release
// ============================================================================
module xmult_acc #(
    parameter int BUS_WIDTH = 16,
    parameter int ACC_WIDTH = 40,
    parameter int N_TERMS   = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [2*BUS_WIDTH-1:0] prod_in,
    input  logic                   prod_valid,
    output logic                   prod_ready,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic                   ovf,
    output logic [CNT_WIDTH-1:0]   count
);

    localparam int                   C_PROD_WIDTH = 2 * BUS_WIDTH;
    localparam logic [CNT_WIDTH-1:0] C_LAST_COUNT = CNT_WIDTH'(N_TERMS);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_ovf;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   w_xfer;
    logic                   w_restart;
    logic [CNT_WIDTH-1:0]   w_count_inc;
    logic [ACC_WIDTH:0]     w_sum;

    assign prod_ready  = (r_state == ST_ACC) && !clear && !rst;
    assign w_xfer      = prod_valid && prod_ready;
    assign w_count_inc = r_count + CNT_WIDTH'(1);
    // Extra MSB of the sum is the carry-out folded into the sticky flag.
    assign w_sum       = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - C_PROD_WIDTH){1'b0}}, prod_in};
    assign w_restart   = clear || ((r_state == ST_DONE) && acc_ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_xfer && (w_count_inc == C_LAST_COUNT)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (acc_ready) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
        if (clear) begin
            w_state_nxt = ST_ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_restart) begin
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_count <= '0;
            end else if (w_xfer) begin
                r_acc   <= w_sum[ACC_WIDTH-1:0];
                r_ovf   <= r_ovf | w_sum[ACC_WIDTH];
                r_count <= w_count_inc;
            end
        end
    end

    assign acc_out   = r_acc;
    assign acc_valid = (r_state == ST_DONE);
    assign ovf       = r_ovf;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_xmult_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_xmult_acc
// Purpose  : Self-checking bench for xmult_acc: vector table, corner sequences
//            and a randomized run against an unbounded-sum reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_xmult_acc;

    logic        clk = 1'b0;
    logic        rst;
    // default instance: 40-bit accumulator, 8 terms
    logic        clear, prod_valid, prod_ready, acc_valid, acc_ready, ovf;
    logic [31:0] prod_in;
    logic [39:0] acc_out;
    logic [7:0]  count;
    // narrow instance: 33-bit accumulator, 4 terms
    logic        clear_b, prod_valid_b, prod_ready_b, acc_valid_b, acc_ready_b, ovf_b;
    logic [31:0] prod_in_b;
    logic [32:0] acc_out_b;
    logic [7:0]  count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xmult_acc dut (
        .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .ovf(ovf), .count(count)
    );

    xmult_acc #(.BUS_WIDTH(16), .ACC_WIDTH(33), .N_TERMS(4), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .clear(clear_b), .prod_in(prod_in_b),
        .prod_valid(prod_valid_b), .prod_ready(prod_ready_b), .acc_out(acc_out_b),
        .acc_valid(acc_valid_b), .acc_ready(acc_ready_b), .ovf(ovf_b), .count(count_b)
    );

    typedef struct {
        bit          v;
        logic [31:0] p;
        bit          rdy;
        int          e_cnt;
        bit          e_val;
        logic [63:0] e_acc;
        bit          e_prdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, logic [31:0] p, bit rdy, int cnt, bit val,
                                logic [63:0] acc, bit prdy);
        vec_t t;
        t.v = v; t.p = p; t.rdy = rdy; t.e_cnt = cnt;
        t.e_val = val; t.e_acc = acc; t.e_prdy = prdy;
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(vec_t t, int idx);
        string n;
        prod_valid = t.v; prod_in = t.p; acc_ready = t.rdy;
        @(posedge clk); #1;
        n = $sformatf("vec%0d", idx);
        chk({n, ".count"},      64'(count),      64'(t.e_cnt));
        chk({n, ".acc_valid"},  64'(acc_valid),  64'(t.e_val));
        chk({n, ".acc_out"},    64'(acc_out),    t.e_acc);
        chk({n, ".ovf"},        64'(ovf),        64'd0);
        chk({n, ".prod_ready"}, 64'(prod_ready), 64'(t.e_prdy));
    endtask

    // Reference: keep the true (unbounded) sum; the DUT value is it modulo
    // 2^W and the sticky carry is set exactly when the true sum reached 2^W.
    task automatic model_step(input bit v, input bit r, input bit c, input logic [31:0] p,
                              input int n, inout logic [63:0] s, inout int k, inout bit d);
        if (c) begin
            s = 0; k = 0; d = 0;
        end else if (d) begin
            if (r) begin s = 0; k = 0; d = 0; end
        end else if (v) begin
            s = s + 64'(p);
            k = k + 1;
            if (k == n) d = 1;
        end
    endtask

    task automatic idle_all();
        clear = 0; prod_valid = 0; prod_in = 0; acc_ready = 0;
        clear_b = 0; prod_valid_b = 0; prod_in_b = 0; acc_ready_b = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        logic [63:0] run;
        logic [63:0] sa, sb;
        int          ka, kb, k;
        bit          da, db;
        bit          va, ra, ca, vb, rb, cb;
        logic [31:0] pa, pb;

        // ---------------- vector table ----------------
        run = 0;
        for (int i = 0; i < 8; i++) begin
            run += 64'(2 * (i + 2));
            tbl.push_back(mk(1, 32'(2 * (i + 2)), 0, i + 1, i == 7, run, i != 7));
        end
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 32'd99, 0, 8, 1, 64'd88, 0));
        tbl.push_back(mk(1, 32'd99, 1, 0, 0, 64'd0, 1));
        run = 0; k = 0;
        for (int j = 0; j < 16; j++) begin
            if (j % 2 == 1) begin
                run += 64'(2 * (k + 2));
                tbl.push_back(mk(1, 32'(2 * (k + 2)), 0, k + 1, k == 7, run, k != 7));
                k++;
            end else begin
                tbl.push_back(mk(0, 32'hFFFF_0000, 0, k, 0, run, 1));
            end
        end
        tbl.push_back(mk(0, 32'd0, 1, 0, 0, 64'd0, 1));

        // ---------------- reset ----------------
        idle_all();
        rst = 1;
        @(posedge clk); #1;
        chk("rst.prod_ready_low", 64'(prod_ready), 64'd0);
        @(posedge clk); #1;
        chk("rst.acc_out",   64'(acc_out),   64'd0);
        chk("rst.count",     64'(count),     64'd0);
        chk("rst.ovf",       64'(ovf),       64'd0);
        chk("rst.acc_valid", 64'(acc_valid), 64'd0);
        rst = 0; #1;
        chk("rst.prod_ready_high", 64'(prod_ready), 64'd1);

        foreach (tbl[i]) apply(tbl[i], i);

        // ---------------- clear mid-sum ----------------
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1; prod_in = 10; @(posedge clk); #1;
        end
        chk("clr.pre_count", 64'(count), 64'd3);
        clear = 1; #1;
        chk("clr.prod_ready", 64'(prod_ready), 64'd0);
        @(posedge clk); #1;
        clear = 0; prod_valid = 0;
        chk("clr.acc_out", 64'(acc_out), 64'd0);
        chk("clr.count",   64'(count),   64'd0);
        chk("clr.ovf",     64'(ovf),     64'd0);
        for (int i = 0; i < 8; i++) begin
            prod_valid = 1; prod_in = 1; @(posedge clk); #1;
        end
        prod_valid = 0;
        chk("clr.sum_valid", 64'(acc_valid), 64'd1);
        chk("clr.sum",       64'(acc_out),   64'd8);
        acc_ready = 1; @(posedge clk); #1; acc_ready = 0;
        chk("clr.release", 64'(acc_valid), 64'd0);

        // ---------------- reset while holding a sum ----------------
        for (int i = 0; i < 8; i++) begin
            prod_valid = 1; prod_in = 32'(2 * (i + 2)); @(posedge clk); #1;
        end
        prod_valid = 0;
        chk("rdone.acc_out",   64'(acc_out),   64'd88);
        chk("rdone.acc_valid", 64'(acc_valid), 64'd1);
        rst = 1; @(posedge clk); #1; rst = 0; #1;
        chk("rdone.acc_valid_after", 64'(acc_valid),  64'd0);
        chk("rdone.acc_out_after",   64'(acc_out),    64'd0);
        chk("rdone.count_after",     64'(count),      64'd0);
        chk("rdone.prod_ready",      64'(prod_ready), 64'd1);

        // ---------------- overflow on the 33-bit instance ----------------
        for (int i = 0; i < 4; i++) begin
            prod_valid_b = 1; prod_in_b = 32'hFFFF_FFFF; @(posedge clk); #1;
        end
        prod_valid_b = 0;
        chk("ovf.acc_valid", 64'(acc_valid_b), 64'd1);
        chk("ovf.acc_out",   64'(acc_out_b),   64'h1_FFFF_FFFC);
        chk("ovf.flag",      64'(ovf_b),       64'd1);
        acc_ready_b = 1; @(posedge clk); #1; acc_ready_b = 0;
        chk("ovf.cleared", 64'(ovf_b),   64'd0);
        chk("ovf.count",   64'(count_b), 64'd0);

        // ---------------- randomized run, both instances ----------------
        idle_all();
        do_reset();
        sa = 0; sb = 0; ka = 0; kb = 0; da = 0; db = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            va = ($urandom_range(0, 3) != 0); ra = ($urandom_range(0, 2) == 0);
            ca = ($urandom_range(0, 40) == 0); pa = $urandom;
            vb = ($urandom_range(0, 3) != 0); rb = ($urandom_range(0, 2) == 0);
            cb = ($urandom_range(0, 40) == 0); pb = $urandom;
            prod_valid = va; acc_ready = ra; clear = ca; prod_in = pa;
            prod_valid_b = vb; acc_ready_b = rb; clear_b = cb; prod_in_b = pb;
            #1;
            chk("rnd.a.prod_ready", 64'(prod_ready),   64'(!da && !ca));
            chk("rnd.b.prod_ready", 64'(prod_ready_b), 64'(!db && !cb));
            @(posedge clk); #1;
            model_step(va, ra, ca, pa, 8, sa, ka, da);
            model_step(vb, rb, cb, pb, 4, sb, kb, db);
            chk("rnd.a.acc_out",   64'(acc_out),   sa & ((64'd1 << 40) - 1));
            chk("rnd.a.ovf",       64'(ovf),       64'((sa >> 40) != 0));
            chk("rnd.a.count",     64'(count),     64'(ka));
            chk("rnd.a.acc_valid", 64'(acc_valid), 64'(da));
            chk("rnd.b.acc_out",   64'(acc_out_b),   sb & ((64'd1 << 33) - 1));
            chk("rnd.b.ovf",       64'(ovf_b),       64'((sb >> 33) != 0));
            chk("rnd.b.count",     64'(count_b),     64'(kb));
            chk("rnd.b.acc_valid", 64'(acc_valid_b), 64'(db));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xmult_acc.md
Name: xmult_acc

Overview:
- Downstream stage of the xMult combinational multiplier: consumes its 2*bus_width-bit unsigned product C and accumulates n_terms products into one dot-product sum.
- Input side is a valid/ready handshake driven by the operand sequencer feeding xMult.
- Output side presents the finished sum with a valid/ready handshake and a sticky overflow flag.

Parameters:
- bus_width, 16, operand width of the upstream multiplier; product width is 2*bus_width.
- acc_width, 40, accumulator width; must be >= 2*bus_width.
- n_terms, 8, products per sum; range 1..255.
- cnt_width, 8, width of the count output; must hold n_terms.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort/restart of the current sum.
- prod_in  input  2*bus_width  unsigned product from the multiplier (its C output).
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  block accepts prod_in this cycle.
- acc_out  output  acc_width  running and final accumulated sum.
- acc_valid  output  1  acc_out holds a completed sum.
- acc_ready  input  1  consumer takes the completed sum.
- ovf  output  1  sticky carry-out of acc_width within the current sum.
- count  output  cnt_width  number of products accepted into the current sum.

Behaviour:
- Reset (rst=1 at a clock edge): state=ACC, acc_out=0, count=0, ovf=0, acc_valid=0. rst has highest priority in every state, including mid-sum and in DONE.
- States:
  - ACC: collecting products.
  - DONE: holding a completed sum.
- prod_ready is combinational: prod_ready = (state==ACC) && !clear && !rst.
- A transfer occurs when prod_valid && prod_ready. On a transfer:
  - acc_out <= acc_out + zero-extended prod_in, taken modulo 2^acc_width.
  - ovf <= ovf | carry-out of that addition.
  - count <= count+1.
- Gaps in prod_valid leave all state unchanged.
- ACC -> DONE: on the transfer that makes count reach n_terms.
  - acc_valid rises the next cycle, carrying the sum that includes that final product.
  - Latency: 1 cycle from the last accepted product to acc_valid.
- DONE:
  - prod_ready=0; acc_valid=1.
  - acc_out, ovf and count are held stable while acc_ready=0 (backpressure, unlimited duration).
- DONE -> ACC: when acc_ready=1.
  - Next cycle: acc_valid=0, acc_out=0, count=0, ovf=0.
  - A prod_valid asserted in that same cycle is not accepted (prod_ready was 0); the source holds it.
- clear=1 (below rst in priority, above everything else), from any state:
  - Next cycle: acc_out=0, count=0, ovf=0, acc_valid=0, state=ACC.
  - A product presented in the same cycle is not consumed.
  - A pending DONE sum is discarded.
- acc_out is observable mid-sum (running value) but is only meaningful when acc_valid=1.
- n_terms=1: every accepted product goes straight to DONE.
- All arithmetic is unsigned. There is no saturation; the sum wraps and is flagged by ovf.

Test Plan:
- Reset then normal sum: rst for 2 cycles; feed prod_in = 2*(i+2) for i=0..7 on consecutive cycles (the upstream multiplier with A=2, B=i+2). Required: count goes 1..8; acc_valid=1 the cycle after the 8th transfer; acc_out=88 (0x58); ovf=0.
- Backpressure: same stream with acc_ready=0 for 5 cycles after DONE. Required: acc_out=88, acc_valid=1 and prod_ready=0 held throughout; after acc_ready pulses, acc_out=0 and count=0 the next cycle.
- Bubbles: same 8 products with prod_valid low every other cycle. Required: sum still 88; acc_valid 1 cycle after the 8th transfer; no extra accumulation during gaps.
- Overflow (acc_width=33, n_terms=4): four products of 0xFFFFFFFF. Required: acc_out=0x1_FFFF_FFFC and ovf=1 at acc_valid; ovf clears after acc_ready.
- Clear mid-sum: feed 3 products of 10, then clear=1 together with prod_valid and prod_in=10. Required: next cycle acc_out=0, count=0, ovf=0; that product not counted; 8 further products of 1 give acc_out=8.
- Reset in DONE: reach DONE with sum 88 and acc_ready=0; assert rst. Required: next cycle acc_valid=0, acc_out=0, count=0, prod_ready=1.
